// File: rtl/bus_pkg.sv
// Shared AHB-Lite transfer types plus the arbiter state encoding.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } transfer_kind;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } transfer_burst;

    typedef enum logic [2:0] {
        SIZE_BYTE   = 3'd0,
        SIZE_HALF   = 3'd1,
        SIZE_WORD   = 3'd2,
        SIZE_DWORD  = 3'd3,
        SIZE_4WORD  = 3'd4,
        SIZE_8WORD  = 3'd5,
        SIZE_16WORD = 3'd6,
        SIZE_32WORD = 3'd7
    } transfer_size;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } transfer_response;

    typedef enum logic [1:0] {
        PARK,
        ACTIVE,
        BURST,
        LOCKED
    } arb_state_t;

    localparam int BEAT_W = 4;

    // Beats remaining after the NONSEQ of a fixed burst; zero for SINGLE/INCR.
    function automatic logic [BEAT_W-1:0] burst_beats(transfer_burst b);
        case (b)
            WRAP4, INCR4:   return 4'd3;
            WRAP8, INCR8:   return 4'd7;
            WRAP16, INCR16: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter-facing bundle: per-master request/lock, owner transfer info, grant outputs.
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int MASTER_COUNT = 2
);
    localparam int SEL_W = $clog2(MASTER_COUNT);

    logic [MASTER_COUNT-1:0] req;
    logic [MASTER_COUNT-1:0] lock;
    transfer_kind            trans;
    transfer_burst           burst;
    logic                    ready;
    logic [MASTER_COUNT-1:0] grant;
    logic [SEL_W-1:0]        addr_sel;
    logic [SEL_W-1:0]        data_sel;
    logic                    mastlock;

    modport master (
        output req, lock, trans, burst, ready,
        input  grant, addr_sel, data_sel, mastlock
    );

    modport slave (
        input  req, lock, trans, burst, ready,
        output grant, addr_sel, data_sel, mastlock
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_picker #(
    parameter int REQ_COUNT = 2,
    localparam int IDX_W = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [IDX_W-1:0]     start,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    logic [IDX_W:0] pos;

    always_comb begin
        found = 1'b0;
        index = start;
        pos   = '0;
        for (int unsigned i = 0; i < REQ_COUNT; i++) begin
            pos = {1'b0, start} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(REQ_COUNT)) begin
                pos = pos - (IDX_W+1)'(REQ_COUNT);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                index = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin AHB-Lite master arbiter; hands over only at transfer boundaries,
// never splitting fixed-length bursts or locked sequences.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MASTER_COUNT   = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input logic          clk,
    input logic          rst,
    bus_arbiter_if.slave bus
);

    localparam int SEL_W = $clog2(MASTER_COUNT);
    localparam logic [SEL_W-1:0]        PARK_SEL   = SEL_W'(DEFAULT_MASTER);
    localparam logic [MASTER_COUNT-1:0] PARK_GRANT = MASTER_COUNT'(1) << DEFAULT_MASTER;

    arb_state_t              state, state_next;
    logic [BEAT_W-1:0]       beat_cnt, cnt_next;
    logic [SEL_W-1:0]        owner, owner_next, data_owner;
    logic [MASTER_COUNT-1:0] grant_q, grant_d;
    logic                    mastlock_q, mastlock_d;

    logic                    owner_lock, owner_req, fixed_burst;
    logic                    boundary, handover;
    logic [SEL_W:0]          start_sum;
    logic [SEL_W-1:0]        start_sel;
    logic                    pick_found;
    logic [SEL_W-1:0]        pick_index;

    assign owner_lock  = bus.lock[owner];
    assign owner_req   = bus.req[owner];
    assign fixed_burst = (burst_beats(bus.burst) != '0);

    assign start_sum = {1'b0, owner} + (SEL_W+1)'(1);
    assign start_sel = (start_sum >= (SEL_W+1)'(MASTER_COUNT)) ? '0 : start_sum[SEL_W-1:0];

    rr_picker #(
        .REQ_COUNT(MASTER_COUNT)
    ) u_picker (
        .req  (bus.req),
        .start(start_sel),
        .found(pick_found),
        .index(pick_index)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PARK;
            beat_cnt   <= '0;
            owner      <= PARK_SEL;
            data_owner <= PARK_SEL;
            grant_q    <= PARK_GRANT;
            mastlock_q <= 1'b0;
        end else if (bus.ready) begin
            state      <= state_next;
            beat_cnt   <= cnt_next;
            owner      <= owner_next;
            data_owner <= owner;
            grant_q    <= grant_d;
            mastlock_q <= mastlock_d;
        end
    end

    always_comb begin
        cnt_next = beat_cnt;
        case (bus.trans)
            IDLE:    cnt_next = '0;
            NONSEQ:  cnt_next = burst_beats(bus.burst);
            SEQ:     if (beat_cnt != '0) cnt_next = beat_cnt - 4'd1;
            default: cnt_next = beat_cnt;
        endcase

        // Lock release only counts as a boundary if it does not open a fixed burst.
        boundary = (bus.trans == IDLE)
                || (bus.trans == NONSEQ && bus.burst == SINGLE)
                || (bus.trans == SEQ && fixed_burst && cnt_next == '0)
                || (bus.burst == INCR && !owner_req)
                || (state == LOCKED && cnt_next == '0);
        handover = !owner_lock && boundary;

        owner_next = owner;
        state_next = state;
        if (handover) begin
            owner_next = pick_found ? pick_index : PARK_SEL;
            state_next = pick_found ? ACTIVE : PARK;
        end else if (owner_lock &&
                     (state == LOCKED || bus.trans == NONSEQ || bus.trans == SEQ)) begin
            state_next = LOCKED;
        end else if (cnt_next != '0) begin
            state_next = BURST;
        end else begin
            state_next = ACTIVE;
        end
    end

    always_comb begin
        grant_d             = '0;
        grant_d[owner_next] = 1'b1;
        mastlock_d          = owner_lock && (bus.trans != IDLE);
    end

    assign bus.grant    = grant_q;
    assign bus.addr_sel = owner;
    assign bus.data_sel = data_owner;
    assign bus.mastlock = mastlock_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters, default master 0.
module tb_bus_arbiter;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    bus_arbiter_if #(.MASTER_COUNT(2)) bus ();

    bus_arbiter #(
        .MASTER_COUNT  (2),
        .DEFAULT_MASTER(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return to parked-on-M0 with data_sel settled.
    task automatic park();
        bus.req   = 2'b00;
        bus.lock  = 2'b00;
        bus.trans = IDLE;
        bus.burst = SINGLE;
        bus.ready = 1'b1;
        step();
        step();
    endtask

    // Give M0 the bus as an ACTIVE owner before it starts a sequence.
    task automatic own_m0();
        bus.req   = 2'b01;
        bus.trans = IDLE;
        bus.burst = SINGLE;
        step();
    endtask

    task automatic test_reset();
        bus.req   = 2'b00;
        bus.lock  = 2'b00;
        bus.trans = IDLE;
        bus.burst = SINGLE;
        bus.ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests_run++;
        if ({bus.grant, bus.addr_sel, bus.data_sel, bus.mastlock} !== 5'b01_0_0_0) begin
            tests_failed++;
            $display("FAIL reset_state: got grant=%b addr=%b data=%b lock=%b, expected 01 0 0 0",
                     bus.grant, bus.addr_sel, bus.data_sel, bus.mastlock);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if ({bus.grant, bus.addr_sel, bus.data_sel, bus.mastlock} !== 5'b01_0_0_0) begin
                tests_failed++;
                $display("FAIL idle_hold[%0d]: got grant=%b addr=%b data=%b lock=%b, expected 01 0 0 0",
                         i, bus.grant, bus.addr_sel, bus.data_sel, bus.mastlock);
            end
        end
    endtask

    task automatic test_idle_handover();
        bus.req = 2'b10;
        step();
        tests_run++;
        if ({bus.grant, bus.addr_sel, bus.data_sel} !== 4'b10_1_0) begin
            tests_failed++;
            $display("FAIL idle_grant: got grant=%b addr=%b data=%b, expected 10 1 0",
                     bus.grant, bus.addr_sel, bus.data_sel);
        end
        step();
        tests_run++;
        if ({bus.grant, bus.data_sel} !== 3'b10_1) begin
            tests_failed++;
            $display("FAIL idle_data_sel: got grant=%b data=%b, expected 10 1",
                     bus.grant, bus.data_sel);
        end
        bus.req = 2'b00;
        step();
        tests_run++;
        if ({bus.grant, bus.addr_sel} !== 3'b01_0) begin
            tests_failed++;
            $display("FAIL idle_repark: got grant=%b addr=%b, expected 01 0",
                     bus.grant, bus.addr_sel);
        end
        park();
    endtask

    task automatic test_burst_incr4();
        transfer_kind seq [5] = '{NONSEQ, SEQ, BUSY, SEQ, SEQ};
        own_m0();
        bus.req   = 2'b11;
        bus.burst = INCR4;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus.grant !== 2'b01) begin
                tests_failed++;
                $display("FAIL incr4_hold[%0d]: got grant=%b expected 01", i, bus.grant);
            end
            bus.trans = seq[i];
            step();
        end
        tests_run++;
        if ({bus.grant, bus.addr_sel, bus.data_sel} !== 4'b10_1_0) begin
            tests_failed++;
            $display("FAIL incr4_handover: got grant=%b addr=%b data=%b, expected 10 1 0",
                     bus.grant, bus.addr_sel, bus.data_sel);
        end
        park();
    endtask

    task automatic test_stall_incr8();
        own_m0();
        bus.req   = 2'b11;
        bus.burst = INCR8;
        // NONSEQ, then beat 2 held off for three cycles, then seven accepted SEQs in total.
        for (int i = 0; i < 11; i++) begin
            tests_run++;
            if (bus.grant !== 2'b01) begin
                tests_failed++;
                $display("FAIL incr8_hold[%0d]: got grant=%b expected 01", i, bus.grant);
            end
            bus.trans = (i == 0) ? NONSEQ : SEQ;
            bus.ready = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            step();
        end
        tests_run++;
        if ({bus.grant, bus.addr_sel} !== 3'b10_1) begin
            tests_failed++;
            $display("FAIL incr8_handover: got grant=%b addr=%b, expected 10 1",
                     bus.grant, bus.addr_sel);
        end
        park();
    endtask

    task automatic test_lock();
        own_m0();
        bus.req   = 2'b11;
        bus.lock  = 2'b01;
        bus.trans = NONSEQ;
        bus.burst = SINGLE;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({bus.grant, bus.mastlock} !== 3'b01_1) begin
                tests_failed++;
                $display("FAIL lock_hold[%0d]: got grant=%b mastlock=%b, expected 01 1",
                         i, bus.grant, bus.mastlock);
            end
        end
        bus.lock = 2'b00;
        step();
        tests_run++;
        if ({bus.grant, bus.mastlock} !== 3'b10_0) begin
            tests_failed++;
            $display("FAIL lock_release: got grant=%b mastlock=%b, expected 10 0",
                     bus.grant, bus.mastlock);
        end
        park();
    endtask

    task automatic test_incr_release();
        own_m0();
        bus.req   = 2'b11;
        bus.burst = INCR;
        bus.trans = NONSEQ;
        step();
        bus.trans = SEQ;
        step();
        tests_run++;
        if (bus.grant !== 2'b01) begin
            tests_failed++;
            $display("FAIL incr_keep: got grant=%b expected 01", bus.grant);
        end
        bus.req = 2'b10;
        step();
        tests_run++;
        if (bus.grant !== 2'b10) begin
            tests_failed++;
            $display("FAIL incr_release: got grant=%b expected 10", bus.grant);
        end
        park();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_grant [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        logic       exp_data  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.req   = 2'b11;
        bus.trans = NONSEQ;
        bus.burst = SINGLE;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (bus.grant !== exp_grant[i] || bus.data_sel !== exp_data[i]) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got grant=%b data=%b, expected %b %b",
                         i, bus.grant, bus.data_sel, exp_grant[i], exp_data[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.grant, bus.addr_sel, bus.data_sel, bus.mastlock} !== 5'b01_0_0_0) begin
            tests_failed++;
            $display("FAIL async_reset: got grant=%b addr=%b data=%b lock=%b, expected 01 0 0 0",
                     bus.grant, bus.addr_sel, bus.data_sel, bus.mastlock);
        end
        #10 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_handover();
        test_burst_incr4();
        test_stall_incr8();
        test_lock();
        test_incr_release();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
